// File: rtl/cv32e40p_irq_source_unit.sv
// SoC-side interrupt source unit driving the core's irq_i[31:0] lines.
// Synchronizes raw peripheral lines, latches edge-type events as pending, passes level-type
// lines straight through, and retires edge pendings on the core's acknowledge.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   src_i            raw asynchronous peripheral event/level lines
//   irq_o            registered interrupt lines to the core
//   irq_ack_i/id_i   core acknowledge pulse and the acknowledged id
//   reg_*            single-cycle register port (0 PENDING, 1 SET, 2 CLR, 3 ENABLE,
//                    4 OVERFLOW, 5 ACKERR); read data returns one cycle after the request
//   ack_err_o        sticky flag: ack seen for an id whose pending bit was 0
module cv32e40p_irq_source_unit #(
  parameter logic [31:0] IRQ_MASK    = 32'hFFFF_0888,
  parameter logic [31:0] EDGE_MASK   = 32'hFFFF_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_i,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [2:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o,
  output logic        ack_err_o
);

  localparam logic [31:0] EdgeBits  = EDGE_MASK & IRQ_MASK;
  localparam logic [31:0] LevelBits = ~EDGE_MASK & IRQ_MASK;

  logic [31:0] sync_s;
  logic [31:0] prev_q;
  logic [31:0] pend_q, pend_d;
  logic [31:0] en_q, en_d;
  logic [31:0] ovf_q, ovf_d;
  logic        ack_err_q, ack_err_d;
  logic [31:0] irq_q;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;

  // Synchronizer: sync_s is src_i delayed SYNC_STAGES cycles
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_s = src_i & IRQ_MASK;
  end else begin : g_sync
    logic [31:0] stage_q [SYNC_STAGES];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= src_i & IRQ_MASK;
        for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign sync_s = stage_q[SYNC_STAGES-1];
  end

  logic        wr, rd;
  logic [31:0] rise, ack_vec, set_vec, clr_vec, pend_clr, ovf_clr;
  logic        ack_miss;

  always_comb begin
    wr       = reg_req_i & reg_we_i;
    rd       = reg_req_i & ~reg_we_i;
    rise     = sync_s & ~prev_q & EdgeBits;
    ack_vec  = irq_ack_i ? (32'd1 << irq_id_i) : '0;
    set_vec  = (wr && reg_addr_i == 3'd1) ? reg_wdata_i : '0;
    clr_vec  = (wr && reg_addr_i == 3'd2) ? reg_wdata_i : '0;
    ovf_clr  = (wr && reg_addr_i == 3'd4) ? reg_wdata_i : '0;
    pend_clr = ack_vec | clr_vec;
    ack_miss = irq_ack_i & ~pend_q[irq_id_i];

    // Edge lines: set beats clear so a new event is never lost; level lines follow sync_s
    pend_d = ((((pend_q & ~pend_clr) | rise | set_vec) & EdgeBits) | (sync_s & LevelBits));

    // A rise on an already-pending line that is not being retired this cycle is lost
    ovf_d = ((ovf_q & ~ovf_clr) | (rise & pend_q & ~pend_clr)) & EdgeBits;

    en_d = en_q;
    if (wr && reg_addr_i == 3'd3) en_d = reg_wdata_i & IRQ_MASK;

    ack_err_d = ack_err_q;
    if (wr && reg_addr_i == 3'd5 && reg_wdata_i[0]) ack_err_d = 1'b0;
    if (ack_miss) ack_err_d = 1'b1;

    // Read data reflects pre-write state; idle cycles return 0
    rdata_d = '0;
    if (rd) begin
      unique case (reg_addr_i)
        3'd0:    rdata_d = pend_q;
        3'd3:    rdata_d = en_q;
        3'd4:    rdata_d = ovf_q;
        3'd5:    rdata_d = {31'b0, ack_err_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pend_q    <= '0;
      en_q      <= IRQ_MASK;
      ovf_q     <= '0;
      ack_err_q <= 1'b0;
      irq_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= sync_s;
      pend_q    <= pend_d & IRQ_MASK;
      en_q      <= en_d & IRQ_MASK;
      ovf_q     <= ovf_d & IRQ_MASK;
      ack_err_q <= ack_err_d;
      irq_q     <= pend_q & en_q & IRQ_MASK;
      rvalid_q  <= rd;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_o        = irq_q;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign ack_err_o    = ack_err_q;

endmodule

// File: tb/tb_cv32e40p_irq_source_unit.sv
// Directed bench for cv32e40p_irq_source_unit with default parameters (SYNC_STAGES = 2).
// Inputs change and outputs are sampled on the falling edge.
module tb_cv32e40p_irq_source_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_i;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [2:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic        ack_err_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  cv32e40p_irq_source_unit dut (
    .clk          (clk),
    .rst          (rst),
    .src_i        (src_i),
    .irq_o        (irq_o),
    .irq_ack_i    (irq_ack_i),
    .irq_id_i     (irq_id_i),
    .reg_req_i    (reg_req_i),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_rdata_o  (reg_rdata_o),
    .ack_err_o    (ack_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack_i = 1'b1;
    irq_id_i  = id;
    tick(1);
    irq_ack_i = 1'b0;
    irq_id_i  = '0;
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    reg_req_i   = 1'b1;
    reg_we_i    = 1'b1;
    reg_addr_i  = addr;
    reg_wdata_i = data;
    tick(1);
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_wdata_i = '0;
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = addr;
    tick(1);
    reg_req_i  = 1'b0;
    check("rvalid", {31'b0, reg_rvalid_o}, 32'd1);
    data = reg_rdata_o;
  endtask

  initial begin
    rst         = 1'b1;
    src_i       = '0;
    irq_ack_i   = 1'b0;
    irq_id_i    = '0;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_irq", irq_o, 32'h0);
    check("rst_ackerr", {31'b0, ack_err_o}, 32'h0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    reg_read(3'd3, rd_val);
    check("rst_enable", rd_val, 32'hFFFF_0888);
    reg_read(3'd0, rd_val);
    check("rst_pending", rd_val, 32'h0);

    // T1: edge line 16, latency SYNC_STAGES+2 = 4, ack drops irq_o after 2 cycles
    src_i[16] = 1'b1;
    tick(3);
    check("t1_irq_early", {31'b0, irq_o[16]}, 32'd0);
    tick(1);
    check("t1_irq_set", irq_o, 32'h0001_0000);
    ack(5'd16);
    check("t1_irq_ack1", {31'b0, irq_o[16]}, 32'd1);
    tick(1);
    check("t1_irq_ack2", {31'b0, irq_o[16]}, 32'd0);
    tick(3);
    check("t1_irq_held", {31'b0, irq_o[16]}, 32'd0);
    check("t1_ackerr", {31'b0, ack_err_o}, 32'd0);
    src_i[16] = 1'b0;

    // T2: level line 11 follows the input; ack has no effect
    src_i[11] = 1'b1;
    tick(4);
    check("t2_irq_set", irq_o, 32'h0000_0800);
    ack(5'd11);
    tick(2);
    check("t2_irq_after_ack", {31'b0, irq_o[11]}, 32'd1);
    check("t2_ackerr", {31'b0, ack_err_o}, 32'd0);
    src_i[11] = 1'b0;
    tick(3);
    check("t2_irq_fall_early", {31'b0, irq_o[11]}, 32'd1);
    tick(1);
    check("t2_irq_fall", {31'b0, irq_o[11]}, 32'd0);

    // T3: new rise on line 20 lands in the same cycle as ack of the old pending
    src_i[20] = 1'b1;
    tick(4);
    check("t3_irq_first", {31'b0, irq_o[20]}, 32'd1);
    src_i[20] = 1'b0;
    tick(3);
    src_i[20] = 1'b1;
    tick(2);
    ack(5'd20);
    reg_read(3'd0, rd_val);
    check("t3_pending", rd_val, 32'h0010_0000);
    reg_read(3'd4, rd_val);
    check("t3_overflow", rd_val, 32'h0);
    check("t3_ackerr", {31'b0, ack_err_o}, 32'd0);
    ack(5'd20);
    src_i[20] = 1'b0;

    // T4: two rises on line 17 without ack set overflow; W1C clears it
    src_i[17] = 1'b1;
    tick(4);
    src_i[17] = 1'b0;
    tick(3);
    src_i[17] = 1'b1;
    tick(4);
    reg_read(3'd4, rd_val);
    check("t4_overflow", rd_val, 32'h0002_0000);
    reg_write(3'd4, 32'h0002_0000);
    reg_read(3'd4, rd_val);
    check("t4_overflow_clr", rd_val, 32'h0);
    ack(5'd17);
    src_i[17] = 1'b0;
    tick(2);
    reg_read(3'd0, rd_val);
    check("t4_pending_clr", rd_val, 32'h0);

    // T5: register port
    reg_write(3'd3, 32'h0);
    reg_write(3'd1, 32'h8000_0000);
    reg_read(3'd0, rd_val);
    check("t5_pending_set", rd_val, 32'h8000_0000);
    tick(1);
    check("t5_irq_masked", irq_o, 32'h0);
    reg_write(3'd3, 32'hFFFF_0888);
    tick(1);
    check("t5_irq_enabled", irq_o, 32'h8000_0000);
    reg_write(3'd0, 32'hFFFF_FFFF);
    reg_read(3'd0, rd_val);
    check("t5_pending_ro", rd_val, 32'h8000_0000);
    reg_write(3'd1, 32'h0000_0008);
    reg_read(3'd0, rd_val);
    check("t5_set_level", rd_val, 32'h8000_0000);
    reg_read(3'd1, rd_val);
    check("t5_set_reads0", rd_val, 32'h0);
    reg_write(3'd3, 32'hFFFF_FFFF);
    reg_read(3'd3, rd_val);
    check("t5_enable_mask", rd_val, 32'hFFFF_0888);
    reg_write(3'd2, 32'h8000_0000);
    reg_read(3'd0, rd_val);
    check("t5_clr", rd_val, 32'h0);

    // T6: ack error, ACKERR clear, mid-stream reset
    ack(5'd5);
    check("t6_ackerr_set", {31'b0, ack_err_o}, 32'd1);
    reg_read(3'd5, rd_val);
    check("t6_ackerr_read", rd_val, 32'd1);
    reg_write(3'd5, 32'd1);
    check("t6_ackerr_clr", {31'b0, ack_err_o}, 32'd0);
    ack(5'd5);
    reg_write(3'd1, 32'h8000_0000);
    tick(2);
    check("t6_irq_before_rst", irq_o, 32'h8000_0000);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_irq", irq_o, 32'h0);
    check("t6_rst_ackerr", {31'b0, ack_err_o}, 32'd0);
    check("t6_rst_rvalid", {31'b0, reg_rvalid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reg_read(3'd3, rd_val);
    check("t6_enable_after_rst", rd_val, 32'hFFFF_0888);
    reg_read(3'd0, rd_val);
    check("t6_pending_after_rst", rd_val, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
